// File: rtl/boot_pkg.sv
// ---------------------------------------------------------------------------
// boot_pkg
//
// Shared definitions for the UART boot loader:
//   state_t          - boot loader FSM states
//   ACK_BYTE_DEFAULT - default byte sent after a successful load
//   ERR_BYTE_DEFAULT - default byte sent when the length is rejected
//   WORD_IDX_W       - width of the imem word index (covers 0..256)
// ---------------------------------------------------------------------------
package boot_pkg;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        ACK    = 3'd4,
        ERR_TX = 3'd5,
        RUN    = 3'd6,
        HALT   = 3'd7
    } state_t;

    localparam logic [7:0] ACK_BYTE_DEFAULT = 8'hAA;
    localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hEE;

    localparam int WORD_IDX_W = 9;

endpackage

// File: rtl/boot_loader_if.sv
// ---------------------------------------------------------------------------
// boot_loader_if
//
// Bundles the rx FIFO read side, the tx FIFO write side and the imem write
// port that the boot loader owns during boot.
//   uart_rx_data  rx FIFO head byte (first-word-fall-through)
//   empty         rx FIFO empty
//   uart_rd_en    pop the rx FIFO this cycle
//   uart_tx_data  byte to push into the tx FIFO
//   full          tx FIFO full
//   uart_wr_en    push uart_tx_data this cycle
//   imem_we       imem write strobe
//   imem_addr     word-aligned imem byte address
//   imem_wdata    imem write data
//
// master: the boot loader side. slave: the FIFO / memory side.
// ---------------------------------------------------------------------------
interface boot_loader_if #(
    parameter int ADDR_W = 10
);

    logic [7:0]        uart_rx_data;
    logic              empty;
    logic              uart_rd_en;
    logic [7:0]        uart_tx_data;
    logic              full;
    logic              uart_wr_en;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  uart_rx_data,
        input  empty,
        input  full,
        output uart_rd_en,
        output uart_tx_data,
        output uart_wr_en,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output uart_rx_data,
        output empty,
        output full,
        input  uart_rd_en,
        input  uart_tx_data,
        input  uart_wr_en,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

endinterface

// File: rtl/word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
//
// Big-endian byte-to-word shift register. The first byte shifted in after
// reset (or after a completed word) ends up in bits [31:24].
//   clk      system clock
//   rst      synchronous active-high reset; clears word and byte count
//   byte_in  byte to shift in
//   shift    shift byte_in in and advance the byte count
//   word     assembled 32-bit word
//   last     high while the next shift completes a word (byte count == 3)
// ---------------------------------------------------------------------------
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        shift,
    output logic [31:0] word,
    output logic        last
);

    logic [1:0] byte_cnt;

    // The counter wraps 3 -> 0 on the fourth shift, so no explicit clear is
    // needed between words.
    always_ff @(posedge clk) begin
        if (rst) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (shift) begin
            word     <= {word[23:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign last = (byte_cnt == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// ---------------------------------------------------------------------------
// boot_loader
//
// Loads a program from the UART rx FIFO into instruction memory and keeps
// the CPU in reset until the load finishes. Host protocol: a 2-byte
// big-endian word count N, then N big-endian 32-bit words.
// After a good load it sends ACK_BYTE and hands both FIFOs to the CPU as a
// combinational pass-through. A count above MAX_WORDS sends ERR_BYTE and
// halts with the CPU still in reset.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   bus (master)      rx FIFO, tx FIFO and imem write port
//   cpu_uart_rd_en    CPU rx pop request (only honoured in RUN)
//   cpu_uart_tx_data  CPU tx byte (only honoured in RUN)
//   cpu_uart_wr_en    CPU tx push request (only honoured in RUN)
//   cpu_rst           active-high CPU reset
//   done              load complete, CPU running
//   error             length rejected, halted
// ---------------------------------------------------------------------------
module boot_loader
    import boot_pkg::*;
#(
    parameter int         MAX_WORDS = 256,
    parameter int         ADDR_W    = 10,
    parameter logic [7:0] ACK_BYTE  = ACK_BYTE_DEFAULT,
    parameter logic [7:0] ERR_BYTE  = ERR_BYTE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    boot_loader_if.master        bus,
    input  logic                 cpu_uart_rd_en,
    input  logic [7:0]           cpu_uart_tx_data,
    input  logic                 cpu_uart_wr_en,
    output logic                 cpu_rst,
    output logic                 done,
    output logic                 error
);

    state_t                  state;
    state_t                  state_next;

    logic [15:0]             len;
    logic [WORD_IDX_W-1:0]   word_idx;

    logic                    rd_en;
    logic                    wr_en;
    logic [7:0]              tx_data;
    logic                    we;
    logic                    shift;
    logic                    latch_hi;
    logic                    latch_lo;

    logic [31:0]             word;
    logic                    last;

    logic [15:0]             len_rx;
    logic [15:0]             last_idx;
    logic                    word_last;
    logic [WORD_IDX_W+1:0]   byte_addr;

    // Full count as it will look once the low byte currently at the FIFO
    // head is latched; lets LEN_LO decide its successor in the same cycle.
    assign len_rx    = {len[15:8], bus.uart_rx_data};

    // N is never 0 in WRITE (N==0 skips straight to ACK), so N-1 is safe.
    assign last_idx  = len - 16'd1;
    assign word_last = ({{(16-WORD_IDX_W){1'b0}}, word_idx} == last_idx);
    assign byte_addr = {word_idx, 2'b00};

    word_assembler u_word_assembler (
        .clk     (clk),
        .rst     (rst),
        .byte_in (bus.uart_rx_data),
        .shift   (shift),
        .word    (word),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LEN_HI;
            len      <= '0;
            word_idx <= '0;
        end else begin
            state <= state_next;
            if (latch_hi) begin
                len[15:8] <= bus.uart_rx_data;
            end
            if (latch_lo) begin
                len[7:0] <= bus.uart_rx_data;
            end
            if (we) begin
                word_idx <= word_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        tx_data    = 8'h00;
        we         = 1'b0;
        shift      = 1'b0;
        latch_hi   = 1'b0;
        latch_lo   = 1'b0;

        case (state)
            LEN_HI: begin
                rd_en    = !bus.empty;
                latch_hi = !bus.empty;
                if (!bus.empty) begin
                    state_next = LEN_LO;
                end
            end

            LEN_LO: begin
                rd_en    = !bus.empty;
                latch_lo = !bus.empty;
                if (!bus.empty) begin
                    if (len_rx == 16'd0) begin
                        state_next = ACK;
                    end else if (len_rx > 16'(MAX_WORDS)) begin
                        state_next = ERR_TX;
                    end else begin
                        state_next = DATA;
                    end
                end
            end

            DATA: begin
                rd_en = !bus.empty;
                shift = !bus.empty;
                if (!bus.empty && last) begin
                    state_next = WRITE;
                end
            end

            WRITE: begin
                we         = 1'b1;
                state_next = word_last ? ACK : DATA;
            end

            // tx_data is held for the whole state so it stays stable while
            // the tx FIFO is full.
            ACK: begin
                tx_data = ACK_BYTE;
                wr_en   = !bus.full;
                if (!bus.full) begin
                    state_next = RUN;
                end
            end

            ERR_TX: begin
                tx_data = ERR_BYTE;
                wr_en   = !bus.full;
                if (!bus.full) begin
                    state_next = HALT;
                end
            end

            RUN: begin
                rd_en   = cpu_uart_rd_en;
                wr_en   = cpu_uart_wr_en;
                tx_data = cpu_uart_tx_data;
            end

            HALT: begin
                state_next = HALT;
            end

            default: begin
                state_next = LEN_HI;
            end
        endcase

        // While rst is held the registered state may still be stale, so the
        // FIFO and imem strobes are forced quiet independently of state.
        if (rst) begin
            rd_en    = 1'b0;
            wr_en    = 1'b0;
            tx_data  = 8'h00;
            we       = 1'b0;
            shift    = 1'b0;
            latch_hi = 1'b0;
            latch_lo = 1'b0;
        end
    end

    assign bus.uart_rd_en   = rd_en;
    assign bus.uart_wr_en   = wr_en;
    assign bus.uart_tx_data = tx_data;

    // Address and data are zeroed outside WRITE so imem sees a clean bus.
    assign bus.imem_we    = we;
    assign bus.imem_addr  = we ? ADDR_W'(byte_addr) : '0;
    assign bus.imem_wdata = we ? word : 32'h0;

    assign cpu_rst = rst || (state != RUN);
    assign done    = !rst && (state == RUN);
    assign error   = !rst && (state == HALT);

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_uart_rd_en;
    logic [7:0] cpu_uart_tx_data;
    logic       cpu_uart_wr_en;
    logic       cpu_rst;
    logic       done;
    logic       error;

    boot_loader_if #(.ADDR_W(10)) bus ();

    boot_loader #(
        .MAX_WORDS (256),
        .ADDR_W    (10),
        .ACK_BYTE  (8'hAA),
        .ERR_BYTE  (8'hEE)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .cpu_uart_rd_en   (cpu_uart_rd_en),
        .cpu_uart_tx_data (cpu_uart_tx_data),
        .cpu_uart_wr_en   (cpu_uart_wr_en),
        .cpu_rst          (cpu_rst),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    wr_t        exp_wr_q[$];
    logic [7:0] exp_tx_q[$];
    logic [7:0] rx_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops = 0;
    int gap = 0;
    int stall_cnt = 0;
    int full_cnt = 0;
    int full_drop_cyc = -1;
    int first_wr_cyc = -1;
    int run_cyc = -1;
    int start_cyc = 0;
    int pops_before = 0;
    bit chk_release = 1'b0;
    bit expect_err = 1'b0;
    bit bp_mode = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h required=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_rx();
        bus.empty        = (rx_q.size() == 0) || (stall_cnt > 0);
        bus.uart_rx_data = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_q.push_back(b);
    endtask

    task automatic exp_write(input logic [9:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_wr_q.push_back(e);
    endtask

    // One clock cycle: monitor at the falling edge, model FIFOs after the
    // rising edge.
    task automatic tick();
        bit popped;
        wr_t e;
        @(negedge clk);
        cyc++;
        if (rst) begin
            check_val("rst_rd_en", bus.uart_rd_en, 0);
            check_val("rst_wr_en", bus.uart_wr_en, 0);
            check_val("rst_tx_data", bus.uart_tx_data, 0);
            check_val("rst_imem_we", bus.imem_we, 0);
            check_val("rst_imem_addr", bus.imem_addr, 0);
            check_val("rst_imem_wdata", bus.imem_wdata, 0);
            check_val("rst_cpu_rst", cpu_rst, 1);
            check_val("rst_done", done, 0);
            check_val("rst_error", error, 0);
        end
        if (chk_release) begin
            check_val("rel_done", done, !expect_err);
            check_val("rel_cpu_rst", cpu_rst, expect_err);
            check_val("rel_error", error, expect_err);
            chk_release = 1'b0;
        end
        if (!rst && done && run_cyc < 0) run_cyc = cyc;
        if (bus.imem_we) begin
            if (exp_wr_q.size() == 0) begin
                check_val("unexpected_we", bus.imem_we, 0);
            end else begin
                e = exp_wr_q.pop_front();
                check_val("wr_addr", bus.imem_addr, e.addr);
                check_val("wr_data", bus.imem_wdata, e.data);
            end
        end
        if (!done && bus.uart_rd_en && bus.empty)
            check_val("rd_en_while_empty", bus.uart_rd_en, 0);
        if (!done && bus.uart_wr_en) begin
            check_val("wr_en_while_full", bus.full, 0);
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (exp_tx_q.size() == 0) begin
                check_val("unexpected_tx", bus.uart_wr_en, 0);
            end else begin
                check_val("tx_byte", bus.uart_tx_data, exp_tx_q.pop_front());
                check_val("pre_rel_cpu_rst", cpu_rst, 1);
                chk_release = 1'b1;
            end
        end
        popped = bus.uart_rd_en && !bus.empty;
        @(posedge clk);
        #1;
        if (popped && rx_q.size() > 0) begin
            void'(rx_q.pop_front());
            pops++;
            stall_cnt = gap;
        end else if (stall_cnt > 0) begin
            stall_cnt--;
        end
        if (full_cnt > 0) begin
            full_cnt--;
            if (full_cnt == 0) begin
                bus.full = 1'b0;
                full_drop_cyc = cyc + 1;
            end
        end
        drive_rx();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        rx_q.delete();
        stall_cnt = 0;
        drive_rx();
        tick();
        tick();
        rst = 1'b0;
        run_cyc = -1;
        first_wr_cyc = -1;
        full_drop_cyc = -1;
        chk_release = 1'b0;
        pops = 0;
    endtask

    task automatic run_load(input int budget);
        bit finished;
        finished = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bp_mode && bus.full && full_cnt == 0 && exp_wr_q.size() == 0 && rx_q.size() == 0)
                full_cnt = 5;
            if ((done || error) && exp_wr_q.size() == 0 && exp_tx_q.size() == 0 && !chk_release) begin
                finished = 1'b1;
                break;
            end
        end
        check_val("load_finished", finished, 1);
        check_val("wr_remaining", exp_wr_q.size(), 0);
        check_val("tx_remaining", exp_tx_q.size(), 0);
    endtask

    task automatic two_word_stimulus();
        push_rx(8'h00); push_rx(8'h02);
        push_rx(8'hDE); push_rx(8'hAD); push_rx(8'hBE); push_rx(8'hEF);
        push_rx(8'h01); push_rx(8'h23); push_rx(8'h45); push_rx(8'h67);
        exp_write(10'd0, 32'hDEADBEEF);
        exp_write(10'd4, 32'h01234567);
        exp_tx_q.push_back(8'hAA);
    endtask

    // CPU-side inputs kept active during boot; they must be ignored.
    task automatic cpu_noise();
        cpu_uart_rd_en   = 1'b1;
        cpu_uart_wr_en   = 1'b1;
        cpu_uart_tx_data = 8'h55;
    endtask

    initial begin
        rst              = 1'b1;
        cpu_uart_rd_en   = 1'b0;
        cpu_uart_wr_en   = 1'b0;
        cpu_uart_tx_data = 8'h00;
        bus.full         = 1'b0;
        bus.empty        = 1'b1;
        bus.uart_rx_data = 8'h00;

        // Two-word load at full rate
        cpu_noise();
        expect_err = 1'b0;
        apply_reset();
        two_word_stimulus();
        drive_rx();
        #1;
        check_val("post_rst_rd_en", bus.uart_rd_en, 1);
        check_val("post_rst_cpu_rst", cpu_rst, 1);
        check_val("post_rst_done", done, 0);
        start_cyc = cyc + 1;
        run_load(200);
        check_val("boot_cycles", run_cyc - start_cyc, 13);
        check_val("two_done", done, 1);
        check_val("two_cpu_rst", cpu_rst, 0);

        // Empty program
        cpu_noise();
        apply_reset();
        push_rx(8'h00); push_rx(8'h00);
        exp_tx_q.push_back(8'hAA);
        drive_rx();
        run_load(50);
        check_val("empty_done", done, 1);
        check_val("empty_error", error, 0);

        // Over-length count, trailing bytes stay queued
        cpu_noise();
        expect_err = 1'b1;
        apply_reset();
        push_rx(8'h01); push_rx(8'h01);
        push_rx(8'h11); push_rx(8'h22); push_rx(8'h33); push_rx(8'h44);
        exp_tx_q.push_back(8'hEE);
        drive_rx();
        run_load(50);
        repeat (10) tick();
        check_val("ovl_error", error, 1);
        check_val("ovl_cpu_rst", cpu_rst, 1);
        check_val("ovl_done", done, 0);
        check_val("ovl_pops", pops, 2);
        check_val("ovl_left", rx_q.size(), 4);
        expect_err = 1'b0;

        // Backpressure: rx gaps and tx full at ACK
        cpu_noise();
        apply_reset();
        gap = 3;
        bp_mode = 1'b1;
        bus.full = 1'b1;
        two_word_stimulus();
        drive_rx();
        run_load(300);
        check_val("bp_first_wr", first_wr_cyc, full_drop_cyc);
        check_val("bp_done", done, 1);
        gap = 0;
        bp_mode = 1'b0;
        bus.full = 1'b0;

        // Reset in the middle of a word
        cpu_noise();
        apply_reset();
        push_rx(8'h00); push_rx(8'h01); push_rx(8'hAA); push_rx(8'hBB);
        drive_rx();
        for (int i = 0; i < 20 && pops < 4; i++) tick();
        check_val("mid_pops", pops, 4);
        apply_reset();
        push_rx(8'h00); push_rx(8'h01);
        push_rx(8'h11); push_rx(8'h22); push_rx(8'h33); push_rx(8'h44);
        exp_write(10'd0, 32'h11223344);
        exp_tx_q.push_back(8'hAA);
        drive_rx();
        run_load(100);
        check_val("mid_done", done, 1);

        // Pass-through in RUN
        cpu_uart_wr_en   = 1'b1;
        cpu_uart_tx_data = 8'h41;
        cpu_uart_rd_en   = 1'b1;
        push_rx(8'h5A);
        drive_rx();
        #1;
        check_val("pt_wr_en", bus.uart_wr_en, 1);
        check_val("pt_tx_data", bus.uart_tx_data, 8'h41);
        check_val("pt_rd_en", bus.uart_rd_en, 1);
        check_val("pt_imem_we", bus.imem_we, 0);
        pops_before = pops;
        tick();
        check_val("pt_popped", pops - pops_before, 1);
        cpu_uart_wr_en = 1'b0;
        cpu_uart_rd_en = 1'b0;
        #1;
        check_val("pt_wr_en_off", bus.uart_wr_en, 0);
        check_val("pt_rd_en_off", bus.uart_rd_en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Loads a program over UART into instruction memory and holds the CPU in reset until loading completes. It sits between the UART FIFOs and the CPU core. During boot it owns the rx FIFO, the tx FIFO and the imem write port. After boot it hands both FIFOs to the CPU as a combinational pass-through and releases CPU reset.

## Interface
Parameters:
- MAX_WORDS, 256: imem capacity in 32-bit words.
- ADDR_W, 10: imem byte-address width.
- ACK_BYTE, 8'hAA: byte sent after a successful load.
- ERR_BYTE, 8'hEE: byte sent when the length is rejected.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- uart_rx_data  in  8  rx FIFO head (first-word-fall-through; valid when !empty).
- empty  in  1  rx FIFO empty.
- uart_rd_en  out  1  pops the rx FIFO in the same cycle.
- uart_tx_data  out  8  byte to the tx FIFO.
- full  in  1  tx FIFO full.
- uart_wr_en  out  1  pushes uart_tx_data in the same cycle.
- cpu_uart_rd_en  in  1  CPU rx pop request (used only in RUN).
- cpu_uart_tx_data  in  8  CPU tx byte (used only in RUN).
- cpu_uart_wr_en  in  1  CPU tx push request (used only in RUN).
- imem_we  out  1  imem write strobe.
- imem_addr  out  ADDR_W  word-aligned byte address.
- imem_wdata  out  32  word to write.
- cpu_rst  out  1  active-high CPU reset.
- done  out  1  load complete; CPU running.
- error  out  1  length rejected; halted.

## Operation
**Protocol.** The host sends, in this order:
- a 2-byte big-endian word count N;
- N words, each as 4 bytes, big-endian (the first byte becomes bits [31:24]).

**States.** LEN_HI → LEN_LO → (DATA | ACK | ERR_TX); DATA → WRITE → (DATA | ACK); ACK → RUN; ERR_TX → HALT.
- LEN_HI, LEN_LO:
  - uart_rd_en = !empty.
  - On each pop, latch one length byte.
  - Leaving LEN_LO: N==0 → ACK; N>MAX_WORDS → ERR_TX; otherwise → DATA.
- DATA:
  - uart_rd_en = !empty.
  - Each pop shifts the byte into the word register and increments byte_cnt (0..3).
  - The pop with byte_cnt==3 → WRITE.
- WRITE (exactly 1 cycle):
  - imem_we=1, imem_addr = word_idx<<2, imem_wdata = assembled word.
  - Then word_idx increments; word_idx==N-1 → ACK, else → DATA.
- ACK / ERR_TX:
  - uart_tx_data = ACK_BYTE / ERR_BYTE, uart_wr_en = !full.
  - The state is left on the cycle the push is accepted.
- RUN (terminal until rst):
  - cpu_rst=0, done=1.
  - uart_rd_en = cpu_uart_rd_en, uart_wr_en = cpu_uart_wr_en, uart_tx_data = cpu_uart_tx_data (all combinational).
  - imem_we=0.
- HALT (terminal until rst):
  - error=1, cpu_rst=1.
  - No rd_en, wr_en or imem_we are ever asserted.

**Outside RUN:**
- cpu_uart_* inputs are ignored.
- uart_rd_en is asserted only in LEN_HI, LEN_LO and DATA.
- No byte is popped in WRITE, ACK, ERR_TX or HALT. Bytes beyond N words stay in the FIFO for the CPU.

**Widths.**
- word_idx is 9 bits.
- Maximum address is (MAX_WORDS-1)*4 = 1020, which fits ADDR_W.

## Timing
- **Reset:**
  - Applies on the clk edge where rst=1. Next state is LEN_HI, with byte_cnt=0, word_idx=0, and the length and word registers cleared.
  - While rst=1: cpu_rst=1 and all other outputs are 0, including uart_rd_en, uart_tx_data, imem_addr and imem_wdata.
- **Reset mid-operation:** a partial word is discarded and the next load starts at address 0. Words already written are not scrubbed.
- **Rx throughput:** one byte per cycle when !empty. Empty cycles stall the current state with no side effect.
- **Write latency:** imem_we is asserted the cycle after the 4th byte of a word is popped.
  - Peak rate is 5 cycles per word.
  - Minimum total boot time is 2 + 5N + 1 cycles (ACK) before RUN.
- **Tx backpressure:** ACK/ERR_TX hold uart_tx_data stable while full=1. uart_wr_en never asserts while full=1.
- **Release:** cpu_rst deasserts and done rises on the first RUN cycle, which is the cycle after the ACK push.
- **Outputs:** imem_*, done, error and cpu_rst are registered or decoded from state only. The uart_* outputs may depend combinationally on empty and full.

## Structure
- Package boot_pkg holds:
  - the state enum (LEN_HI, LEN_LO, DATA, WRITE, ACK, ERR_TX, RUN, HALT);
  - ACK_BYTE and ERR_BYTE default constants.
- One sub-module, word_assembler:
  - Ports: clk, rst, byte_in, shift.
  - Outputs: word (32), last (byte_cnt==3).
  - It is a big-endian shift register plus a 2-bit counter.
- Top level contains the FSM, word_idx, the length register and the RUN pass-through muxes.

## Test plan
- **Two-word load:**
  - Stimulus: rx bytes 00 02 DE AD BE EF 01 23 45 67.
  - Required: writes addr 0 = 0xDEADBEEF and addr 4 = 0x01234567; tx 0xAA once; cpu_rst falls and done=1 one cycle after the tx push.
- **Empty program:**
  - Stimulus: rx 00 00.
  - Required: no imem_we; tx 0xAA; RUN entered.
- **Over-length:**
  - Stimulus: rx 01 01 (N=257), followed by 4 more bytes.
  - Required: error=1; tx 0xEE; cpu_rst stays 1; the 4 trailing bytes are never popped.
- **Backpressure:**
  - Stimulus: the two-word load with empty=1 for 3 cycles between every byte, and full=1 for 5 cycles at ACK.
  - Required: identical imem writes; uart_wr_en is first asserted on the cycle full drops.
- **Reset mid-word:**
  - Stimulus: rst pulsed after 00 01 AA BB, then a clean load of 00 01 11 22 33 44.
  - Required: a single write addr 0 = 0x11223344; no write containing AA or BB.
- **Pass-through in RUN:**
  - Stimulus: cpu_uart_wr_en=1 with cpu_uart_tx_data=0x41; cpu_uart_rd_en=1 with empty=0.
  - Required: uart_wr_en=1 and uart_tx_data=0x41 in the same cycle; uart_rd_en=1; imem_we stays 0.
